// File: rtl/riscv_interrupt_encoder.sv
// rtl/riscv_interrupt_encoder.sv - edge-triggered interrupt pending/priority encoder with request/ack handshake
//
// Purpose: captures rising edges on the standard and fast interrupt lines into
// a pending register. It presents the highest-priority eligible id to the core
// and holds it until the core acks it, the line becomes ineligible, or the
// optional timeout expires.
//
// Ports:
//   clk_i           clock, all state on rising edge
//   rst_ni          synchronous active-low reset
//   irq_software_i  software interrupt line (id 3)
//   irq_timer_i     timer interrupt line (id 7)
//   irq_external_i  external interrupt line (id 11)
//   irq_fast_i      fast interrupt lines 0..14 (id 16+n)
//   irq_enable_i    per-line mask {sw, timer, ext, fast[14:0]}
//   global_en_i     global interrupt enable
//   irq_ack_i       core acknowledge of the presented id
//   irq_req_o       interrupt request to the core
//   irq_id_o        presented id (0 when not requesting)
//   irq_pending_o   pending register, same layout as irq_enable_i
//   spurious_ack_o  one-cycle pulse after an ack seen outside REQ
module riscv_interrupt_encoder #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic [17:0] irq_enable_i,
  input  logic        global_en_i,
  input  logic        irq_ack_i,
  output logic        irq_req_o,
  output logic [4:0]  irq_id_o,
  output logic [17:0] irq_pending_o,
  output logic        spurious_ack_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [17:0]   r_prev;
  logic [17:0]   r_pending;
  logic [4:0]    r_id;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          r_spurious;

  logic [17:0]   w_lines;
  logic [17:0]   w_rise;
  logic [17:0]   w_eligible;
  logic [17:0]   w_id_mask;
  logic [17:0]   w_clr;
  logic [4:0]    w_best_id;
  logic          w_id_eligible;
  logic          w_timeout;

  assign w_lines    = {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
  // r_armed stays low for the first edge after reset so that a line held high
  // through reset release is absorbed into r_prev instead of looking like a rise.
  assign w_rise     = w_lines & ~r_prev & {18{r_armed}};
  assign w_eligible = r_pending & irq_enable_i & {18{global_en_i}};

  // Lowest priority first; each later match overrides, so fast14 wins overall.
  always_comb begin
    w_best_id = 5'd0;
    if (w_eligible[16]) w_best_id = 5'd7;
    if (w_eligible[17]) w_best_id = 5'd3;
    if (w_eligible[15]) w_best_id = 5'd11;
    for (int n = 0; n < 15; n++) begin
      if (w_eligible[n]) w_best_id = 5'(16 + n);
    end
  end

  // Pending-register bit owned by the currently latched id.
  always_comb begin
    w_id_mask = '0;
    case (r_id)
      5'd3:    w_id_mask[17] = 1'b1;
      5'd7:    w_id_mask[16] = 1'b1;
      5'd11:   w_id_mask[15] = 1'b1;
      default: begin
        for (int n = 0; n < 15; n++) begin
          if (r_id == 5'(16 + n)) w_id_mask[n] = 1'b1;
        end
      end
    endcase
  end

  assign w_id_eligible = |(w_id_mask & w_eligible);
  assign w_clr         = ((r_state == REQ) && irq_ack_i) ? w_id_mask : '0;
  assign w_timeout     = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Ack is tested first so it overrides withdrawal and timeout.
  always_comb begin
    w_state_next = r_state;
    irq_req_o    = 1'b0;
    irq_id_o     = 5'd0;
    case (r_state)
      IDLE: begin
        if (|w_eligible) w_state_next = REQ;
      end
      REQ: begin
        irq_req_o = 1'b1;
        irq_id_o  = r_id;
        if (irq_ack_i)                        w_state_next = GAP;
        else if (!w_id_eligible || w_timeout) w_state_next = IDLE;
      end
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_prev     <= w_lines;
      r_armed    <= 1'b1;
      // Set is OR-ed after the clear so a same-cycle rise wins.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if ((r_state == IDLE) && (|w_eligible)) r_id <= w_best_id;
      // Zero outside REQ, so the count restarts on every entry to REQ.
      r_cnt      <= (r_state == REQ) ? r_cnt + 1'b1 : '0;
      r_spurious <= irq_ack_i && (r_state != REQ);
    end
  end

  assign irq_pending_o  = r_pending;
  assign spurious_ack_o = r_spurious;

endmodule

// File: tb/tb_riscv_interrupt_encoder.sv
// tb/tb_riscv_interrupt_encoder.sv - scoreboard bench for riscv_interrupt_encoder
module tb_riscv_interrupt_encoder;

  localparam int TO = 4;
  // Ids from highest to lowest priority.
  localparam int PRIO [18] = '{30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20, 19, 18, 17, 16, 11, 3, 7};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] lines;
  logic [17:0] en;
  logic        gen;
  logic        ack;
  logic        req;
  logic [4:0]  id;
  logic [17:0] pend;
  logic        spur;

  always #5 clk = ~clk;

  riscv_interrupt_encoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .irq_software_i (lines[17]),
    .irq_timer_i    (lines[16]),
    .irq_external_i (lines[15]),
    .irq_fast_i     (lines[14:0]),
    .irq_enable_i   (en),
    .global_en_i    (gen),
    .irq_ack_i      (ack),
    .irq_req_o      (req),
    .irq_id_o       (id),
    .irq_pending_o  (pend),
    .spurious_ack_o (spur)
  );

  typedef struct packed {
    logic        req;
    logic [4:0]  id;
    logic [17:0] pend;
    logic        spur;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state, keyed by interrupt id.
  logic m_pend [32];
  logic m_prev [32];
  logic m_armed, m_pres, m_gap, m_spur;
  int   m_cur, m_age;

  function automatic int bit_of(input int idv);
    case (idv)
      3:       return 17;
      7:       return 16;
      11:      return 15;
      default: return idv - 16;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic model_step();
    logic elig [32];
    int   best;
    int   d;
    logic ackd;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_armed = 1'b0; m_pres = 1'b0; m_gap = 1'b0; m_spur = 1'b0;
      m_cur = 0; m_age = 0;
      return;
    end
    for (int i = 0; i < 32; i++) elig[i] = 1'b0;
    best = -1;
    for (int k = 0; k < 18; k++) begin
      d = PRIO[k];
      elig[d] = m_pend[d] && en[bit_of(d)] && gen;
      if (best < 0 && elig[d]) best = d;
    end
    m_spur = ack && !m_pres;
    ackd   = m_pres && ack;
    for (int k = 0; k < 18; k++) begin
      d = PRIO[k];
      if (m_armed && lines[bit_of(d)] && !m_prev[d]) m_pend[d] = 1'b1;
      else if (ackd && d == m_cur)                   m_pend[d] = 1'b0;
      m_prev[d] = lines[bit_of(d)];
    end
    if (m_pres) begin
      if (ack) begin
        m_pres = 1'b0;
        m_gap  = 1'b1;
      end else if (!elig[m_cur]) begin
        m_pres = 1'b0;
      end else if (m_age + 1 == TO) begin
        m_pres = 1'b0;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (best >= 0) begin
      m_pres = 1'b1;
      m_cur  = best;
      m_age  = 0;
    end
    m_armed = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_step();
    e.req  = m_pres;
    e.id   = m_pres ? 5'(m_cur) : 5'd0;
    e.spur = m_spur;
    e.pend = '0;
    for (int k = 0; k < 18; k++) e.pend[bit_of(PRIO[k])] = m_pend[PRIO[k]];
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk_out(input string name, input logic r, input logic [4:0] i);
    chk({name, "_req"}, 32'(req), 32'(r));
    chk({name, "_id"}, 32'(id), 32'(i));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_req", 32'(req), 32'(e.req));
      chk("sb_id", 32'(id), 32'(e.id));
      chk("sb_pending", 32'(pend), 32'(e.pend));
      chk("sb_spurious", 32'(spur), 32'(e.spur));
    end
  end

  initial begin
    rst_n = 1'b0; lines = '0; en = '1; gen = 1'b1; ack = 1'b0;
    step(); step();
    chk_out("reset", 1'b0, 5'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    chk("reset_spur", 32'(spur), 32'd0);
    rst_n = 1'b1; step();

    // timer: pending after one edge, request after two, ack clears
    lines[16] = 1'b1; step();
    chk("timer_pend_set", 32'(pend[16]), 32'd1);
    chk("timer_req_early", 32'(req), 32'd0);
    step(); chk_out("timer", 1'b1, 5'd7);
    ack = 1'b1; step(); ack = 1'b0;
    chk("timer_ack_pend", 32'(pend[16]), 32'd0);
    chk("timer_ack_req", 32'(req), 32'd0);
    lines[16] = 1'b0; step(); step();

    // fast[2] and external together: fast first, then external
    lines[2] = 1'b1; lines[15] = 1'b1; step(); step();
    chk_out("dual_first", 1'b1, 5'd18);
    ack = 1'b1; step(); ack = 1'b0;
    step(); step(); chk_out("dual_second", 1'b1, 5'd11);
    ack = 1'b1; step(); ack = 1'b0;
    lines[2] = 1'b0; lines[15] = 1'b0; step(); step();

    // higher-priority arrival while presenting does not preempt
    lines[15] = 1'b1; step(); step(); chk_out("preempt_hold0", 1'b1, 5'd11);
    lines[14] = 1'b1; step(); step(); chk_out("preempt_hold1", 1'b1, 5'd11);
    ack = 1'b1; step(); ack = 1'b0;
    step(); step(); chk_out("preempt_next", 1'b1, 5'd30);
    ack = 1'b1; step(); ack = 1'b0;
    lines = '0; step(); step();

    // timeout: 4 REQ cycles, one idle cycle, re-request same id
    lines[17] = 1'b1; step(); step(); chk_out("to_enter", 1'b1, 5'd3);
    for (int k = 0; k < 3; k++) begin
      step(); chk_out("to_hold", 1'b1, 5'd3);
    end
    step(); chk_out("to_withdraw", 1'b0, 5'd0);
    step(); chk_out("to_rereq", 1'b1, 5'd3);
    ack = 1'b1; step(); ack = 1'b0;
    lines[17] = 1'b0; step(); step();

    // global disable withdraws and keeps pending
    lines[16] = 1'b1; step(); step(); chk_out("gen_req", 1'b1, 5'd7);
    gen = 1'b0; step();
    chk_out("gen_withdraw", 1'b0, 5'd0);
    chk("gen_pend_kept", 32'(pend[16]), 32'd1);
    step(); chk_out("gen_stay_idle", 1'b0, 5'd0);
    gen = 1'b1; step(); chk_out("gen_rereq", 1'b1, 5'd7);
    ack = 1'b1; step(); ack = 1'b0;
    lines[16] = 1'b0; step(); step();

    // spurious ack in IDLE with a masked pending bit
    en[15] = 1'b0; lines[15] = 1'b1; step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("spur_pulse", 32'(spur), 32'd1);
    chk("spur_pend_kept", 32'(pend[15]), 32'd1);
    step(); chk("spur_end", 32'(spur), 32'd0);

    // reset while presenting; line held high through release stays quiet
    en[15] = 1'b1; step(); chk_out("rst_pre", 1'b1, 5'd11);
    rst_n = 1'b0; step();
    chk_out("rst_mid", 1'b0, 5'd0);
    chk("rst_mid_pend", 32'(pend), 32'd0);
    rst_n = 1'b1; step(); step(); step();
    chk_out("rst_held_line", 1'b0, 5'd0);
    chk("rst_held_pend", 32'(pend), 32'd0);
    lines = '0; step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [17:0] tog;
      for (int b = 0; b < 18; b++) tog[b] = ($urandom_range(11) == 0);
      lines = lines ^ tog;
      if ($urandom_range(25) == 0) en = 18'($urandom) | 18'($urandom);
      if ($urandom_range(40) == 0) gen = ($urandom_range(4) != 0);
      ack   = m_pres ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      rst_n = ($urandom_range(400) != 0);
      step();
    end
    rst_n = 1'b1; ack = 1'b0;
    step(); step();
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
